// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared defaults and state encoding for the instruction-fetch controller.
package imem_fetch_ctrl_pkg;
   localparam int DEF_ADDR_W   = 10;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_RESET_PC = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FETCH = 2'd2,
      DRAIN = 2'd3
   } state_t;
endpackage

// File: rtl/imem_fetch_hold.sv
// Stall skid for the fetch path: captures the presented memory word on the first
// stalled cycle, because the memory has already moved on to the next address.
module imem_fetch_hold
   import imem_fetch_ctrl_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              CLK_SYS,
   input  logic              rst,
   input  logic              active,
   input  logic              flush,
   input  logic              stall,
   input  logic              inflight,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] instr
);
   logic              hold_valid;
   logic [DATA_W-1:0] hold_instr;

   always_ff @(posedge CLK_SYS or negedge rst) begin
      if (!rst) begin
         hold_valid <= 1'b0;
         hold_instr <= '0;
      end else if (!active || flush) begin
         hold_valid <= 1'b0;
      end else if (stall && inflight && !hold_valid) begin
         hold_valid <= 1'b1;
         hold_instr <= mem_rdata;
      end else if (!stall) begin
         hold_valid <= 1'b0;
      end
   end

   assign instr = hold_valid ? hold_instr : mem_rdata;
endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory sequencer: arbitrates the single port between the program
// loader and the fetch path, and owns the PC, stall hold, redirect and drain.
module imem_fetch_ctrl
   import imem_fetch_ctrl_pkg::*;
#(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                DATA_W   = DEF_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
   input  logic              CLK_SYS,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              ld_req,
   output logic              ld_gnt,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   output logic              busy
);
   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] inflight_pc;
   logic              inflight;
   logic              fetching;

   assign fetching = (state == FETCH) || (state == DRAIN);

   always_ff @(posedge CLK_SYS or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ld_req) begin
                  state <= LOAD;
               end else if (start) begin
                  state <= FETCH;
                  pc    <= RESET_PC;
               end
            end
            LOAD: begin
               if (!ld_req) state <= IDLE;
            end
            FETCH: begin
               if (redirect) begin
                  pc       <= redirect_pc;
                  inflight <= 1'b0;
               end else if (stop) begin
                  // An instruction accepted in the stop cycle must not reappear in DRAIN.
                  state    <= DRAIN;
                  inflight <= inflight && stall;
               end else if (!stall) begin
                  pc          <= pc + ADDR_W'(1);
                  inflight    <= 1'b1;
                  inflight_pc <= pc;
               end
            end
            DRAIN: begin
               if (redirect || !inflight || !stall) begin
                  state    <= IDLE;
                  inflight <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   imem_fetch_hold #(
      .DATA_W (DATA_W)
   ) u_hold (
      .CLK_SYS   (CLK_SYS),
      .rst       (rst),
      .active    (fetching),
      .flush     (fetching && redirect),
      .stall     (stall),
      .inflight  (inflight),
      .mem_rdata (mem_rdata),
      .instr     (instr)
   );

   // The loader only writes while it still holds the request; the exit cycle never writes.
   assign ld_gnt      = (state == LOAD);
   assign mem_addr    = (state == LOAD) ? ld_addr : pc;
   assign mem_we      = ld_we && ld_req && (state == LOAD);
   assign mem_wdata   = ld_wdata;
   assign instr_pc    = inflight_pc;
   assign instr_valid = inflight;
   assign busy        = (state != IDLE);
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: loader fill, table-driven fetch sequence, arbitration
// and drain corners, randomized stall/redirect streaming, and mid-fetch reset.
module tb_imem_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        start, stop, ld_req, ld_we, stall, redirect;
   logic [9:0]  ld_addr, redirect_pc, mem_addr, instr_pc;
   logic [31:0] ld_wdata, mem_wdata, instr;
   logic [31:0] mem_rdata = '0;
   logic        ld_gnt, mem_we, instr_valid, busy;
   logic [31:0] mem [1024];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   imem_fetch_ctrl dut (
      .CLK_SYS     (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .ld_req      (ld_req),
      .ld_gnt      (ld_gnt),
      .ld_we       (ld_we),
      .ld_addr     (ld_addr),
      .ld_wdata    (ld_wdata),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .busy        (busy)
   );

   // Single-port synchronous-read memory, one-cycle registered read.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   function automatic logic [31:0] wordf(input int a);
      logic [31:0] av;
      av = a;
      if (a == 0) return 32'h0800_0001;
      if (a == 1) return 32'h0400_0002;
      return 32'h5A00_0000 ^ {av[15:0], ~av[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   typedef struct {
      logic       stall;
      logic       redirect;
      logic [9:0] rpc;
      logic       exp_valid;
      logic [9:0] exp_pc;
   } vec_t;

   vec_t tbl[17];

   // Random-phase reference: a stream of fetched addresses, independent of RTL internals.
   logic       m_valid;
   logic [9:0] m_cur, m_pc;

   initial begin
      tbl[0]  = '{1'b0, 1'b0, 10'd0,    1'b0, 10'd0};
      tbl[1]  = '{1'b0, 1'b0, 10'd0,    1'b1, 10'd0};
      tbl[2]  = '{1'b0, 1'b0, 10'd0,    1'b1, 10'd1};
      tbl[3]  = '{1'b0, 1'b0, 10'd0,    1'b1, 10'd2};
      tbl[4]  = '{1'b1, 1'b0, 10'd0,    1'b1, 10'd3};
      tbl[5]  = '{1'b1, 1'b0, 10'd0,    1'b1, 10'd3};
      tbl[6]  = '{1'b1, 1'b0, 10'd0,    1'b1, 10'd3};
      tbl[7]  = '{1'b0, 1'b0, 10'd0,    1'b1, 10'd3};
      tbl[8]  = '{1'b0, 1'b0, 10'd0,    1'b1, 10'd4};
      tbl[9]  = '{1'b1, 1'b1, 10'd20,   1'b1, 10'd5};
      tbl[10] = '{1'b0, 1'b0, 10'd0,    1'b0, 10'd0};
      tbl[11] = '{1'b0, 1'b0, 10'd0,    1'b1, 10'd20};
      tbl[12] = '{1'b0, 1'b1, 10'd1023, 1'b1, 10'd21};
      tbl[13] = '{1'b0, 1'b0, 10'd0,    1'b0, 10'd0};
      tbl[14] = '{1'b0, 1'b0, 10'd0,    1'b1, 10'd1023};
      tbl[15] = '{1'b0, 1'b0, 10'd0,    1'b1, 10'd0};
      tbl[16] = '{1'b0, 1'b0, 10'd0,    1'b1, 10'd1};

      rst = 1'b0; start = 0; stop = 0; ld_req = 0; ld_we = 0; stall = 0; redirect = 0;
      ld_addr = '0; ld_wdata = '0; redirect_pc = '0;
      for (int i = 0; i < 1024; i++) mem[i] = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ld_gnt", 32'(ld_gnt), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr_pc", 32'(instr_pc), 32'd0);
      rst = 1'b1;
      tick();

      // Fill the whole memory through the loader
      ld_req = 1'b1;
      tick();
      @(negedge clk);
      chk("load_gnt", 32'(ld_gnt), 32'd1);
      chk("load_busy", 32'(busy), 32'd1);
      tick();
      for (int a = 0; a < 1024; a++) begin
         ld_we = 1'b1; ld_addr = 10'(a); ld_wdata = wordf(a);
         if (a == 7) begin
            @(negedge clk);
            chk("load_mem_we", 32'(mem_we), 32'd1);
            chk("load_mem_addr", 32'(mem_addr), 32'd7);
         end
         tick();
      end
      ld_we = 1'b0; ld_req = 1'b0;
      tick();
      $display("load done");

      // Table-driven fetch sequence: latency, stall hold, redirect+stall, wrap
      pulse_start();
      for (int i = 0; i < 17; i++) begin
         stall = tbl[i].stall; redirect = tbl[i].redirect; redirect_pc = tbl[i].rpc;
         @(negedge clk);
         chk($sformatf("row%0d_valid", i), 32'(instr_valid), 32'(tbl[i].exp_valid));
         if (tbl[i].exp_valid) begin
            chk($sformatf("row%0d_pc", i), 32'(instr_pc), 32'(tbl[i].exp_pc));
            chk($sformatf("row%0d_instr", i), instr, wordf(int'(tbl[i].exp_pc)));
         end
         $display("row %0d: stall=%b redirect=%b valid=%b pc=%0d instr=%h",
                  i, stall, redirect, instr_valid, instr_pc, instr);
         tick();
      end
      stall = 0; redirect = 0;

      // Loader is refused during FETCH
      stall = 1'b1; ld_req = 1'b1; ld_we = 1'b1; ld_addr = 10'd5; ld_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("arb_gnt_fetch", 32'(ld_gnt), 32'd0);
      chk("arb_we_fetch", 32'(mem_we), 32'd0);
      chk("arb_pc_fetch", 32'(instr_pc), 32'd2);
      tick();
      // stop while stalled -> DRAIN keeps presenting the held instruction
      stop = 1'b1;
      @(negedge clk);
      chk("stop_we", 32'(mem_we), 32'd0);
      tick();
      stop = 1'b0;
      @(negedge clk);
      chk("drain_busy", 32'(busy), 32'd1);
      chk("drain_valid", 32'(instr_valid), 32'd1);
      chk("drain_instr", instr, wordf(2));
      chk("drain_gnt", 32'(ld_gnt), 32'd0);
      tick();
      stall = 1'b0;
      @(negedge clk);
      chk("drain_accept_pc", 32'(instr_pc), 32'd2);
      tick();
      ld_we = 1'b0;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_valid", 32'(instr_valid), 32'd0);
      tick();
      ld_req = 1'b0; ld_we = 1'b1;
      @(negedge clk);
      chk("arb_gnt_after", 32'(ld_gnt), 32'd1);
      chk("load_exit_we", 32'(mem_we), 32'd0);
      tick();
      ld_we = 1'b0;
      @(negedge clk);
      chk("load_exit_idle", 32'(busy), 32'd0);
      // ld_req has priority over start
      ld_req = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("prio_gnt", 32'(ld_gnt), 32'd1);
      chk("prio_valid", 32'(instr_valid), 32'd0);
      ld_req = 1'b0;
      tick();
      tick();

      // Randomized streaming against the address-stream reference
      pulse_start();
      m_valid = 1'b0; m_pc = 10'd0; m_cur = 10'd0;
      for (int c = 0; c < 400; c++) begin
         stall = ($urandom_range(0, 3) == 0);
         redirect = ($urandom_range(0, 9) == 0);
         redirect_pc = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1020, 1023))
                                                  : 10'($urandom_range(0, 1023));
         @(negedge clk);
         chk("rnd_valid", 32'(instr_valid), 32'(m_valid));
         if (m_valid) begin
            chk("rnd_pc", 32'(instr_pc), 32'(m_cur));
            chk("rnd_instr", instr, wordf(int'(m_cur)));
         end
         if (redirect) begin
            m_valid = 1'b0;
            m_pc    = redirect_pc;
         end else if (!stall) begin
            m_valid = 1'b1;
            m_cur   = m_pc;
            m_pc    = m_pc + 10'd1;
         end
         tick();
      end
      stall = 0; redirect = 0; stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
      @(negedge clk);
      chk("rnd_stop_idle", 32'(busy), 32'd0);
      $display("random phase done");
      tick();

      // Reset mid-FETCH with pc=5
      pulse_start();
      repeat (5) tick();
      @(negedge clk);
      chk("pre_rst_pc", 32'(mem_addr), 32'd5);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(instr_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_we", 32'(mem_we), 32'd0);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_pc", 32'(mem_addr), 32'd0);
      chk("post_rst_valid", 32'(instr_valid), 32'd0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
